counter_game: RTL and testbench

COUNTER_GAME -- requirements
Module: counter_game

---
 rtl/counter_game_pkg.sv | 22 ++
 rtl/counter_game_detect.sv | 45 ++++
 rtl/counter_game.sv | 128 ++++++++++++
 tb/tb_counter_game.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_game_pkg.sv
// counter_game_pkg: shared types and encodings for the counter game.
//   state_t  - game FSM states (IDLE, PLAY, OVER)
//   WHO_*    - encodings for the "who" result output
//   CTRL_*   - step-select encodings of the control input
package counter_game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    localparam logic [1:0] WHO_NONE = 2'b00;
    localparam logic [1:0] WHO_WIN  = 2'b10;
    localparam logic [1:0] WHO_LOSE = 2'b01;

    localparam logic [1:0] CTRL_INC1   = 2'b00;
    localparam logic [1:0] CTRL_INCBIG = 2'b01;
    localparam logic [1:0] CTRL_DEC1   = 2'b10;
    localparam logic [1:0] CTRL_DECBIG = 2'b11;

endpackage

// File: rtl/counter_game_detect.sv
// counter_game_detect: winner/loser detector with pulse spacing.
//   clk, reset  - clock, synchronous active-high reset
//   clear       - synchronous clear of both pulses (game restart)
//   hold        - freeze both pulse registers (pause)
//   active      - detection allowed this cycle (PLAY, no load, not paused)
//   count       - current counter value
//   direction   - 0 = counting up, 1 = counting down
//   win_hit     - combinational: winner pulse registers on this edge
//   lose_hit    - combinational: loser pulse registers on this edge
//   winner      - registered one-cycle win pulse
//   loser       - registered one-cycle lose pulse
module counter_game_detect #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             hold,
    input  logic             active,
    input  logic [WIDTH-1:0] count,
    input  logic             direction,
    output logic             win_hit,
    output logic             lose_hit,
    output logic             winner,
    output logic             loser
);

    logic spaced;

    // Any pulse currently high blocks detection, so pulses never abut.
    assign spaced   = winner | loser;
    assign win_hit  = active && !spaced && (count == '1) && !direction;
    assign lose_hit = active && !spaced && (count == '0) &&  direction;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            winner <= 1'b0;
            loser  <= 1'b0;
        end else if (!hold) begin
            winner <= win_hit;
            loser  <= lose_hit;
        end
    end

endmodule

// File: rtl/counter_game.sv
// counter_game: up/down counter game with win/lose scoring.
// Optional feature macro: GAME_PAUSE_EN adds a pause input.
//   clk, reset  - clock, synchronous active-high reset
//   start       - begin a game from IDLE / restart from OVER
//   init_c      - counter load enable, init_l - load value
//   control     - step select (+1, +BIG_STEP, -1, -BIG_STEP)
//   pause       - (GAME_PAUSE_EN only) freeze play while in PLAY
//   count       - registered counter value
//   direction   - control[1]
//   winner, loser         - registered one-cycle pulses
//   win_score, lose_score - saturating pulse counts
//   gameover    - high while in OVER
//   who         - game result (WHO_NONE / WHO_WIN / WHO_LOSE)
import counter_game_pkg::*;

module counter_game #(
    parameter int WIDTH     = 4,
    parameter int SCORE_W   = 4,
    parameter int MAX_SCORE = 15,
    parameter int BIG_STEP  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               init_c,
    input  logic [WIDTH-1:0]   init_l,
    input  logic [1:0]         control,
`ifdef GAME_PAUSE_EN
    input  logic               pause,
`endif
    output logic [WIDTH-1:0]   count,
    output logic               direction,
    output logic               winner,
    output logic               loser,
    output logic [SCORE_W-1:0] win_score,
    output logic [SCORE_W-1:0] lose_score,
    output logic               gameover,
    output logic [1:0]         who
);

    localparam logic [WIDTH-1:0]   ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0]   BIG    = WIDTH'(BIG_STEP);
    localparam logic [SCORE_W-1:0] MAX    = SCORE_W'(MAX_SCORE);
    localparam logic [SCORE_W-1:0] MAX_M1 = SCORE_W'(MAX_SCORE - 1);

    state_t state, state_next;
    logic   paused;
    logic   restart;
    logic   active;
    logic   win_hit, lose_hit;
    logic   win_final, lose_final;

`ifdef GAME_PAUSE_EN
    assign paused = pause && (state == ST_PLAY);
`else
    assign paused = 1'b0;
`endif

    assign direction  = control[1];
    assign gameover   = (state == ST_OVER);
    assign restart    = (state == ST_OVER) && start;
    assign active     = (state == ST_PLAY) && !init_c && !paused;
    assign win_final  = win_hit  && (win_score  == MAX_M1);
    assign lose_final = lose_hit && (lose_score == MAX_M1);

    counter_game_detect #(.WIDTH(WIDTH)) u_detect (
        .clk       (clk),
        .reset     (reset),
        .clear     (restart),
        .hold      (paused),
        .active    (active),
        .count     (count),
        .direction (direction),
        .win_hit   (win_hit),
        .lose_hit  (lose_hit),
        .winner    (winner),
        .loser     (loser)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start) state_next = ST_PLAY;
            ST_PLAY: if (win_final || lose_final) state_next = ST_OVER;
            ST_OVER: if (start) state_next = ST_PLAY;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= init_c ? init_l : '0;
        end else if (init_c) begin
            count <= init_l;
        end else if ((state == ST_PLAY) && !paused) begin
            unique case (control)
                CTRL_INC1:   count <= count + ONE;
                CTRL_INCBIG: count <= count + BIG;
                CTRL_DEC1:   count <= count - ONE;
                CTRL_DECBIG: count <= count - BIG;
                default:     count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            win_score  <= '0;
            lose_score <= '0;
            who        <= WHO_NONE;
        end else begin
            if (win_hit && (win_score != MAX))
                win_score <= win_score + SCORE_W'(1);
            if (lose_hit && (lose_score != MAX))
                lose_score <= lose_score + SCORE_W'(1);
            if (win_final)
                who <= WHO_WIN;
            else if (lose_final)
                who <= WHO_LOSE;
        end
    end

endmodule

// File: tb/tb_counter_game.sv
// tb_counter_game: directed, self-checking bench for counter_game
// (WIDTH=4, SCORE_W=4, MAX_SCORE=3, BIG_STEP=2).
// Define GAME_PAUSE_EN to also exercise the pause input.
module tb_counter_game;

    logic       clk = 1'b0;
    logic       reset, start, init_c;
    logic [3:0] init_l;
    logic [1:0] control;
    logic       pause;
    logic [3:0] count;
    logic       direction, winner, loser, gameover;
    logic [3:0] win_score, lose_score;
    logic [1:0] who;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    counter_game #(
        .WIDTH     (4),
        .SCORE_W   (4),
        .MAX_SCORE (3),
        .BIG_STEP  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .init_c     (init_c),
        .init_l     (init_l),
        .control    (control),
`ifdef GAME_PAUSE_EN
        .pause      (pause),
`endif
        .count      (count),
        .direction  (direction),
        .winner     (winner),
        .loser      (loser),
        .win_score  (win_score),
        .lose_score (lose_score),
        .gameover   (gameover),
        .who        (who)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n = 1);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; init_c = 1'b1; init_l = 4'd5;
        control = 2'b00; pause = 1'b0;

        // Reset with load
        tick();
        reset = 1'b0; init_c = 1'b0;
        check("rst_count", count, 5);
        check("rst_winner", winner, 0);
        check("rst_loser", loser, 0);
        check("rst_wscore", win_score, 0);
        check("rst_lscore", lose_score, 0);
        check("rst_gameover", gameover, 0);
        check("rst_who", who, 0);
        tick();
        check("idle_hold", count, 5);

        // Count up from 0 to a win
        init_c = 1'b1; init_l = 4'd0; tick(); init_c = 1'b0;
        check("load0", count, 0);
        start = 1'b1; tick(); start = 1'b0;
        check("start_count", count, 0);
        tick(15);
        check("up15_count", count, 15);
        check("up15_winner", winner, 0);
        tick();
        check("win1_count", count, 0);
        check("win1_winner", winner, 1);
        check("win1_wscore", win_score, 1);
        tick();
        check("win1_after", winner, 0);
        check("win1_after_count", count, 1);
        check("dir_up", direction, 0);

        // -BIG_STEP skips zero
        init_c = 1'b1; init_l = 4'd1; tick(); init_c = 1'b0;
        check("load1", count, 1);
        control = 2'b11;
        #1 check("dir_down", direction, 1);
        tick();
        check("decbig_count", count, 15);
        check("decbig_loser", loser, 0);
        tick();
        check("decbig_count2", count, 13);
        check("decbig_lscore", lose_score, 0);

        // +BIG_STEP passes through 15 and wraps
        control = 2'b01;
        tick();
        check("incbig_count", count, 15);
        tick();
        check("incbig_wrap", count, 1);
        check("incbig_winner", winner, 1);
        check("incbig_wscore", win_score, 2);

        // -1 losses until game over
        init_c = 1'b1; init_l = 4'd1; control = 2'b10; tick(); init_c = 1'b0;
        check("load1b", count, 1);
        check("load1b_winner", winner, 0);
        tick();
        check("dec_count0", count, 0);
        check("dec_loser0", loser, 0);
        tick();
        check("loss1_count", count, 15);
        check("loss1_loser", loser, 1);
        check("loss1_lscore", lose_score, 1);
        for (int unsigned k = 2; k <= 3; k++) begin
            tick(15);
            check("lap_count", count, 0);
            check("lap_loser", loser, 0);
            tick();
            check("loss_loser", loser, 1);
            check("loss_lscore", lose_score, k);
        end
        check("over_gameover", gameover, 1);
        check("over_who", who, 1);
        check("over_count", count, 15);
        tick(3);
        check("over_frozen", count, 15);
        check("over_loser_low", loser, 0);
        check("over_lscore", lose_score, 3);
        check("over_wscore", win_score, 2);
        check("over_still", gameover, 1);
        start = 1'b1; tick(); start = 1'b0;
        check("restart_wscore", win_score, 0);
        check("restart_lscore", lose_score, 0);
        check("restart_who", who, 0);
        check("restart_gameover", gameover, 0);
        check("restart_count", count, 15);

        // Load suppresses detection; start ignored in PLAY; reset mid-game
        control = 2'b00; init_c = 1'b1; init_l = 4'd15; tick(); init_c = 1'b0;
        check("sup_count", count, 15);
        check("sup_winner", winner, 0);
        check("sup_wscore", win_score, 0);
        tick();
        check("w1_winner", winner, 1);
        check("w1_wscore", win_score, 1);
        tick(15);
        check("w2_pre", count, 15);
        start = 1'b1; tick(); start = 1'b0;
        check("w2_winner", winner, 1);
        check("w2_wscore", win_score, 2);
        check("w2_play", gameover, 0);
        check("w2_count", count, 0);
        reset = 1'b1; tick(); reset = 1'b0;
        check("mid_rst_count", count, 0);
        check("mid_rst_wscore", win_score, 0);
        check("mid_rst_winner", winner, 0);
        check("mid_rst_gameover", gameover, 0);
        tick();
        check("mid_rst_idle", count, 0);

        // Win the game
        start = 1'b1; tick(); start = 1'b0;
        init_c = 1'b1; init_l = 4'd15; tick(); init_c = 1'b0;
        tick();
        check("g_w1", win_score, 1);
        tick(16);
        check("g_w2", win_score, 2);
        check("g_w2_over", gameover, 0);
        tick(16);
        check("g_w3", win_score, 3);
        check("g_who", who, 2);
        check("g_gameover", gameover, 1);
        check("g_winner", winner, 1);
        tick();
        check("g_winner_low", winner, 0);
        check("g_frozen", count, 0);

`ifdef GAME_PAUSE_EN
        start = 1'b1; tick(); start = 1'b0;
        check("p_restart", count, 0);
        pause = 1'b1; tick(4);
        check("p_count", count, 0);
        check("p_wscore", win_score, 0);
        pause = 1'b0; tick();
        check("p_resume", count, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
